// File: rtl/mult32x32_pkg.sv
// rtl/mult32x32_pkg.sv - shared widths, timeout constant and scheduler state type
package mult32x32_pkg;

    localparam int DATA_W       = 32;
    localparam int PROD_W       = 64;
    localparam int BUSY_TIMEOUT = 2;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } sched_state_t;

endpackage

// File: rtl/mult32x32_sched_if.sv
// rtl/mult32x32_sched_if.sv - operand, multiplier and result signal bundle
interface mult32x32_sched_if #(
    parameter int TAG_W = 4
) ();

    logic                                in_valid;
    logic                                in_ready;
    logic [mult32x32_pkg::DATA_W-1:0]    in_a;
    logic [mult32x32_pkg::DATA_W-1:0]    in_b;
    logic [TAG_W-1:0]                    in_tag;

    logic                                mult_start;
    logic [mult32x32_pkg::DATA_W-1:0]    mult_a;
    logic [mult32x32_pkg::DATA_W-1:0]    mult_b;
    logic                                mult_busy;
    logic [mult32x32_pkg::PROD_W-1:0]    mult_product;

    logic                                out_valid;
    logic                                out_ready;
    logic [mult32x32_pkg::PROD_W-1:0]    out_product;
    logic [TAG_W-1:0]                    out_tag;

    logic                                err;

    modport master (
        output in_valid, in_a, in_b, in_tag,
        input  in_ready,
        input  mult_start, mult_a, mult_b,
        output mult_busy, mult_product,
        input  out_valid, out_product, out_tag,
        output out_ready,
        input  err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag,
        output in_ready,
        output mult_start, mult_a, mult_b,
        input  mult_busy, mult_product,
        output out_valid, out_product, out_tag,
        input  out_ready,
        output err
    );

endinterface

// File: rtl/mult32x32_opfifo.sv
// rtl/mult32x32_opfifo.sv - power-of-two operand FIFO with guarded push/pop
module mult32x32_opfifo
    import mult32x32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2 * DATA_W + 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Extra MSB on each pointer separates full from empty when the indices meet.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; a push into a full FIFO is simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mult32x32_sched.sv
// rtl/mult32x32_sched.sv - schedules queued operand pairs onto a shared multiplier
module mult32x32_sched
    import mult32x32_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
) (
    input logic              clk,
    input logic              reset,
    mult32x32_sched_if.slave bus
);

    localparam int         ENTRY_W      = 2 * DATA_W + TAG_W;
    localparam logic [1:0] TIMEOUT_LAST = 2'(BUSY_TIMEOUT - 1);

    sched_state_t        state;
    sched_state_t        state_nxt;
    logic                load;
    logic                capture;
    logic                timeout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  head;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [TAG_W-1:0]    op_tag;
    logic [1:0]          idle_cnt;
    logic                out_valid_r;
    logic [PROD_W-1:0]   out_product_r;
    logic [TAG_W-1:0]    out_tag_r;
    logic                err_r;

    mult32x32_opfifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_opfifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.in_valid),
        .push_data ({bus.in_tag, bus.in_b, bus.in_a}),
        .pop       (load),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.in_ready    = !fifo_full;
    assign bus.mult_start  = (state == LAUNCH);
    assign bus.mult_a      = op_a;
    assign bus.mult_b      = op_b;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_product = out_product_r;
    assign bus.out_tag     = out_tag_r;
    assign bus.err         = err_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus load/capture/timeout strobes; a launch waits until the result slot is free.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && (!out_valid_r || bus.out_ready)) begin
                    load      = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.mult_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (idle_cnt == TIMEOUT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.mult_busy) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counts idle cycles seen while waiting for the multiplier to go busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   idle_cnt <= '0;
        else if (state != WAIT_BUSY) idle_cnt <= '0;
        else if (!bus.mult_busy)     idle_cnt <= idle_cnt + 2'd1;
    end

    // Operand registers, only reloaded when a new pair is taken from the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a   <= '0;
            op_b   <= '0;
            op_tag <= '0;
        end else if (load) begin
            op_a   <= head[DATA_W-1:0];
            op_b   <= head[2*DATA_W-1:DATA_W];
            op_tag <= head[ENTRY_W-1:2*DATA_W];
        end
    end

    // Result register; a capture wins over a same-cycle consume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r   <= 1'b0;
            out_product_r <= '0;
            out_tag_r     <= '0;
        end else if (capture) begin
            out_valid_r   <= 1'b1;
            out_product_r <= bus.mult_product;
            out_tag_r     <= op_tag;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r   <= 1'b0;
        end
    end

    // Sticky error: multiplier never acknowledged a start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        err_r <= 1'b0;
        else if (timeout) err_r <= 1'b1;
    end

endmodule

// File: tb/tb_mult32x32_sched.sv
// tb/tb_mult32x32_sched.sv - directed self-checking bench for mult32x32_sched
module tb_mult32x32_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          start_cnt = 0;
    int          start_ref = 0;
    logic        stall = 1'b0;
    logic [2:0]  busy_cnt = '0;
    logic [63:0] prod_r = '0;

    mult32x32_sched_if #(.TAG_W(4)) bus ();

    mult32x32_sched #(.TAG_W(4), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mult_busy    = (busy_cnt != 3'd0);
    assign bus.mult_product = prod_r;

    // Stub multiplier: busy for 4 cycles, product is junk until the last busy cycle ends.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
        end else if (bus.mult_start && !stall) begin
            busy_cnt <= 3'd4;
            prod_r   <= 64'hDEAD_BEEF_DEAD_BEEF;
        end else if (busy_cnt != 3'd0) begin
            busy_cnt <= busy_cnt - 3'd1;
            if (busy_cnt == 3'd1) prod_r <= {32'b0, bus.mult_a} * {32'b0, bus.mult_b};
        end
    end

    // Count start pulses.
    always @(posedge clk) begin
        if (bus.mult_start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = t;
        bus.in_valid = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_mult_start", bus.mult_start, 0);
        chk("rst_mult_a", bus.mult_a, 0);
        chk("rst_mult_b", bus.mult_b, 0);
        chk("rst_out_product", bus.out_product, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_err", bus.err, 0);
        tick();

        // Single operation and latency
        cyc = 0;
        drive(32'h0000FFFF, 32'h00010000, 4'd3);
        chk("t1_in_ready_c0", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        go_to(2);
        chk("t1_start_c2", bus.mult_start, 1);
        chk("t1_mult_a", bus.mult_a, 64'h0000FFFF);
        chk("t1_mult_b", bus.mult_b, 64'h00010000);
        go_to(3);
        chk("t1_start_c3", bus.mult_start, 0);
        chk("t1_mult_a_hold", bus.mult_a, 64'h0000FFFF);
        go_to(7);
        chk("t1_valid_c7", bus.out_valid, 0);
        go_to(8);
        chk("t1_valid_c8", bus.out_valid, 1);
        chk("t1_product", bus.out_product, 64'h0000_0000_FFFF_0000);
        chk("t1_tag", bus.out_tag, 3);
        go_to(9);
        chk("t1_valid_c9", bus.out_valid, 0);
        go_to(12);

        // Back-to-back, full FIFO, refused push during simultaneous pop
        cyc = 0;
        start_ref = start_cnt;
        drive(32'd2, 32'd3, 4'd1);
        tick();
        drive(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2);
        tick();
        drive(32'd5, 32'd7, 4'd5);
        tick();
        drive(32'd11, 32'd13, 4'd9);
        chk("t2_full_c3", bus.in_ready, 0);
        go_to(8);
        chk("t2_full_c8", bus.in_ready, 0);
        chk("t2_valid_c8", bus.out_valid, 1);
        chk("t2_product1", bus.out_product, 64'd6);
        chk("t2_tag1", bus.out_tag, 1);
        go_to(9);
        chk("t2_ready_c9", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        chk("t2_start_c9", bus.mult_start, 1);
        chk("t2_mult_a2", bus.mult_a, 64'hFFFFFFFF);
        go_to(14);
        chk("t2_valid_c14", bus.out_valid, 0);
        go_to(15);
        chk("t2_valid_c15", bus.out_valid, 1);
        chk("t2_product2", bus.out_product, 64'hFFFFFFFE_00000001);
        chk("t2_tag2", bus.out_tag, 2);
        go_to(22);
        chk("t2_valid_c22", bus.out_valid, 1);
        chk("t2_product3", bus.out_product, 64'd35);
        chk("t2_tag3", bus.out_tag, 5);
        go_to(29);
        chk("t2_no_fourth_c29", bus.out_valid, 0);
        go_to(30);
        chk("t2_start_count", 64'(start_cnt - start_ref), 3);

        // Backpressure
        cyc = 0;
        bus.out_ready = 1'b0;
        drive(32'd3, 32'd4, 4'd6);
        tick();
        drive(32'd10, 32'd10, 4'd7);
        tick();
        bus.in_valid = 1'b0;
        go_to(8);
        chk("t3_valid_c8", bus.out_valid, 1);
        chk("t3_product_c8", bus.out_product, 64'd12);
        chk("t3_tag_c8", bus.out_tag, 6);
        start_ref = start_cnt;
        go_to(27);
        chk("t3_valid_c27", bus.out_valid, 1);
        chk("t3_product_c27", bus.out_product, 64'd12);
        chk("t3_tag_c27", bus.out_tag, 6);
        chk("t3_no_start", 64'(start_cnt - start_ref), 0);
        chk("t3_in_ready", bus.in_ready, 1);
        go_to(28);
        bus.out_ready = 1'b1;
        go_to(29);
        chk("t3_start_c29", bus.mult_start, 1);
        chk("t3_mult_a", bus.mult_a, 64'd10);
        chk("t3_valid_c29", bus.out_valid, 0);
        go_to(34);
        chk("t3_valid_c34", bus.out_valid, 0);
        go_to(35);
        chk("t3_valid_c35", bus.out_valid, 1);
        chk("t3_product2", bus.out_product, 64'd100);
        chk("t3_tag2", bus.out_tag, 7);
        go_to(37);

        // Busy timeout
        cyc = 0;
        stall = 1'b1;
        drive(32'd7, 32'd8, 4'd2);
        tick();
        bus.in_valid = 1'b0;
        go_to(2);
        chk("t4_start_c2", bus.mult_start, 1);
        go_to(4);
        chk("t4_err_c4", bus.err, 0);
        go_to(5);
        chk("t4_err_c5", bus.err, 1);
        chk("t4_valid_c5", bus.out_valid, 0);
        stall = 1'b0;
        drive(32'd9, 32'd9, 4'd8);
        tick();
        bus.in_valid = 1'b0;
        go_to(7);
        chk("t4_start_c7", bus.mult_start, 1);
        chk("t4_mult_a", bus.mult_a, 64'd9);
        go_to(12);
        chk("t4_valid_c12", bus.out_valid, 0);
        go_to(13);
        chk("t4_valid_c13", bus.out_valid, 1);
        chk("t4_product", bus.out_product, 64'd81);
        chk("t4_tag", bus.out_tag, 8);
        chk("t4_err_sticky", bus.err, 1);
        go_to(15);

        // Reset during WAIT_DONE
        cyc = 0;
        drive(32'd6, 32'd7, 4'd4);
        tick();
        bus.in_valid = 1'b0;
        go_to(5);
        reset = 1'b1;
        go_to(6);
        reset = 1'b0;
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_in_ready", bus.in_ready, 1);
        chk("t5_start", bus.mult_start, 0);
        chk("t5_err", bus.err, 0);
        chk("t5_product", bus.out_product, 0);
        chk("t5_mult_a", bus.mult_a, 0);
        go_to(8);
        chk("t5_valid_c8", bus.out_valid, 0);
        chk("t5_product_c8", bus.out_product, 0);
        go_to(10);

        cyc = 0;
        drive(32'h12345678, 32'h00000010, 4'hF);
        tick();
        bus.in_valid = 1'b0;
        go_to(7);
        chk("t5b_valid_c7", bus.out_valid, 0);
        go_to(8);
        chk("t5b_valid_c8", bus.out_valid, 1);
        chk("t5b_product", bus.out_product, 64'h0000_0001_2345_6780);
        chk("t5b_tag", bus.out_tag, 4'hF);
        go_to(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
